// File: rtl/clock_button_sequencer_if.sv
// Button/command bundle between the board pins and the clock_with_mode_fsm
// command inputs. The sequencer takes the slave side; whoever drives the raw
// buttons and watches the command pulses takes the master side.
interface clock_button_sequencer_if;
  logic [4:0] btn_raw;        // [0] mode, [1] add_hour, [2] add_minute, [3] set_timer, [4] set_alarm
  logic       mode_btn;
  logic       add_hour;
  logic       add_minute;
  logic       set_timer_btn;
  logic       set_alarm_btn;
  logic       busy;

  modport master (
    output btn_raw,
    input  mode_btn,
    input  add_hour,
    input  add_minute,
    input  set_timer_btn,
    input  set_alarm_btn,
    input  busy
  );

  modport slave (
    input  btn_raw,
    output mode_btn,
    output add_hour,
    output add_minute,
    output set_timer_btn,
    output set_alarm_btn,
    output busy
  );
endinterface

// File: rtl/clock_button_sequencer.sv
// Front end for clock_with_mode_fsm: debounces five buttons, grants one button
// at a time by fixed priority (mode > set_alarm > set_timer > add_hour >
// add_minute) and turns each grant into a one-cycle command pulse.
// Optional feature macro BTN_AUTO_REPEAT_EN: when defined, a held add_hour or
// add_minute auto-repeats (first repeat after HOLD_CYCLES, then every
// REPEAT_CYCLES). When undefined, every press yields exactly one pulse.
module clock_button_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 4,
  parameter int REPEAT_CYCLES   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  clock_button_sequencer_if.slave  bus
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GRANT   = 3'd1;
  localparam logic [2:0] S_HOLD    = 3'd2;
  localparam logic [2:0] S_REPEAT  = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("clock_button_sequencer: DEBOUNCE_CYCLES, HOLD_CYCLES and REPEAT_CYCLES must be >= 1");
  end

  // Fixed-priority one-hot winner select.
  function automatic logic [4:0] pick_winner(input logic [4:0] lvl);
    logic [4:0] w;
    w = '0;
    if (lvl[0])      w[0] = 1'b1;
    else if (lvl[4]) w[4] = 1'b1;
    else if (lvl[3]) w[3] = 1'b1;
    else if (lvl[1]) w[1] = 1'b1;
    else if (lvl[2]) w[2] = 1'b1;
    return w;
  endfunction

  // ---- stage p0: debounced levels ----
  logic [4:0]      db_lvl_p0;
  logic [4:0]      db_lvl_nxt;
  logic [DB_W-1:0] db_cnt_p0  [5];
  logic [DB_W-1:0] db_cnt_nxt [5];

  // ---- stage p1: grant FSM and registered outputs ----
  logic [2:0] state_p1;
  logic [2:0] state_nxt;
  logic [4:0] pulse_p1;
  logic [4:0] pulse_nxt;
  logic       busy_p1;

`ifdef BTN_AUTO_REPEAT_EN
  localparam int TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  logic [4:0]       winner_p1;
  logic [4:0]       winner_nxt;
  logic [TMR_W-1:0] tmr_p1;
  logic [TMR_W-1:0] tmr_nxt;
  logic             held_nxt;

  // Look at the level the winner will have after this edge, so a debounced
  // fall coinciding with a due repeat pulse suppresses that pulse.
  assign held_nxt = |(winner_p1 & db_lvl_nxt);
`endif

  // Per-bit debounce: count disagreeing samples, flip the level when the
  // count would reach DEBOUNCE_CYCLES, clear on any agreeing sample.
  always_comb begin
    db_lvl_nxt = db_lvl_p0;
    for (int i = 0; i < 5; i++) begin
      db_cnt_nxt[i] = '0;
      if (bus.btn_raw[i] != db_lvl_p0[i]) begin
        if (db_cnt_p0[i] + DB_W'(1) == DB_W'(DEBOUNCE_CYCLES)) begin
          db_lvl_nxt[i] = bus.btn_raw[i];
        end else begin
          db_cnt_nxt[i] = db_cnt_p0[i] + DB_W'(1);
        end
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_lvl_p0 <= '0;
      for (int i = 0; i < 5; i++) begin
        db_cnt_p0[i] <= '0;
      end
    end else begin
      db_lvl_p0 <= db_lvl_nxt;
      for (int i = 0; i < 5; i++) begin
        db_cnt_p0[i] <= db_cnt_nxt[i];
      end
    end
  end

  // Grant FSM next-state and pulse decode.
  always_comb begin
    state_nxt  = state_p1;
    pulse_nxt  = '0;
`ifdef BTN_AUTO_REPEAT_EN
    winner_nxt = winner_p1;
    tmr_nxt    = tmr_p1;
`endif
    case (state_p1)
      S_IDLE: begin
        if (|db_lvl_p0) begin
          state_nxt  = S_GRANT;
          pulse_nxt  = pick_winner(db_lvl_p0);
`ifdef BTN_AUTO_REPEAT_EN
          winner_nxt = pick_winner(db_lvl_p0);
          tmr_nxt    = '0;
`endif
        end
      end
`ifdef BTN_AUTO_REPEAT_EN
      // GRANT for an adjust button already counts as the first hold cycle.
      S_GRANT, S_HOLD: begin
        if (!(winner_p1[1] | winner_p1[2]) || !held_nxt) begin
          state_nxt = S_RELEASE;
        end else if (tmr_p1 + TMR_W'(1) == TMR_W'(HOLD_CYCLES)) begin
          state_nxt = S_REPEAT;
          pulse_nxt = winner_p1;
          tmr_nxt   = '0;
        end else begin
          state_nxt = S_HOLD;
          tmr_nxt   = tmr_p1 + TMR_W'(1);
        end
      end
      S_REPEAT: begin
        if (!held_nxt) begin
          state_nxt = S_RELEASE;
        end else if (tmr_p1 + TMR_W'(1) == TMR_W'(REPEAT_CYCLES)) begin
          pulse_nxt = winner_p1;
          tmr_nxt   = '0;
        end else begin
          tmr_nxt   = tmr_p1 + TMR_W'(1);
        end
      end
`else
      S_GRANT: begin
        state_nxt = S_RELEASE;
      end
`endif
      // Everything must be released before the next grant; this is what
      // locks out buttons pressed during another button's grant.
      S_RELEASE: begin
        if (db_lvl_p0 == 5'd0) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p1  <= S_IDLE;
      pulse_p1  <= '0;
      busy_p1   <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      winner_p1 <= '0;
      tmr_p1    <= '0;
`endif
    end else begin
      state_p1  <= state_nxt;
      pulse_p1  <= pulse_nxt;
      busy_p1   <= (state_nxt != S_IDLE);
`ifdef BTN_AUTO_REPEAT_EN
      winner_p1 <= winner_nxt;
      tmr_p1    <= tmr_nxt;
`endif
    end
  end

  assign bus.mode_btn      = pulse_p1[0];
  assign bus.add_hour      = pulse_p1[1];
  assign bus.add_minute    = pulse_p1[2];
  assign bus.set_timer_btn = pulse_p1[3];
  assign bus.set_alarm_btn = pulse_p1[4];
  assign bus.busy          = busy_p1;

endmodule

// File: tb/tb_clock_button_sequencer.sv
// Bench for clock_button_sequencer with default parameters. Per-cycle vectors
// for single press, glitch and simultaneous press, plus hand-written
// sequences for auto-repeat, lockout and reset during a hold. Expected values
// follow BTN_AUTO_REPEAT_EN if the bench is built with it defined.
module tb_clock_button_sequencer;

  logic clk;
  logic reset;

  clock_button_sequencer_if bus ();

  clock_button_sequencer #(
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (4),
    .REPEAT_CYCLES   (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] raw;
    logic [4:0] pulse;
    logic       busy;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  // {busy, set_alarm, set_timer, add_minute, add_hour, mode}
  function automatic logic [5:0] obs();
    return {bus.busy, bus.set_alarm_btn, bus.set_timer_btn,
            bus.add_minute, bus.add_hour, bus.mode_btn};
  endfunction

  task automatic add_rows(input logic [4:0] raw, input logic [4:0] pulse,
                          input logic busy, input int n);
    vec_t v;
    v.raw = raw; v.pulse = pulse; v.busy = busy;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  // Drive inputs on the falling edge, then sample just after the rising edge.
  task automatic tick(input logic [4:0] raw, input logic rst_v);
    @(negedge clk);
    bus.btn_raw = raw;
    reset       = rst_v;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx,
                       input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got busy,pulses=%b want %b", name, idx, act, exp);
    end
  endtask

  initial begin
    logic [5:0] exp;
    logic [4:0] raw;
    int         npulse;

    reset       = 1'b1;
    bus.btn_raw = '0;

    // single press: mode high for 8 edges
    add_rows(5'b00001, 5'b00000, 1'b0, 4);
    add_rows(5'b00001, 5'b00001, 1'b1, 1);
    add_rows(5'b00001, 5'b00000, 1'b1, 3);
    add_rows(5'b00000, 5'b00000, 1'b1, 4);
    add_rows(5'b00000, 5'b00000, 1'b0, 2);
    // glitch: add_minute high for 3 edges
    add_rows(5'b00100, 5'b00000, 1'b0, 3);
    add_rows(5'b00000, 5'b00000, 1'b0, 5);
    // simultaneous add_hour + set_alarm for 6 edges
    add_rows(5'b10010, 5'b00000, 1'b0, 4);
    add_rows(5'b10010, 5'b10000, 1'b1, 1);
    add_rows(5'b10010, 5'b00000, 1'b1, 1);
    add_rows(5'b00000, 5'b00000, 1'b1, 4);
    add_rows(5'b00000, 5'b00000, 1'b0, 2);

    // reset state
    for (int i = 0; i < 2; i++) begin
      tick(5'b00000, 1'b1);
      check("reset_state", i, obs(), 6'b000000);
    end

    foreach (vecs[i]) begin
      tick(vecs[i].raw, 1'b0);
      check("vector", i, obs(), {vecs[i].busy, vecs[i].pulse});
    end

    // auto-repeat: add_hour high for 19 edges; debounced fall at edge 23
    // collides with a due repeat pulse, which must be suppressed
    npulse = 0;
    for (int e = 1; e <= 30; e++) begin
      tick((e <= 19) ? 5'b00010 : 5'b00000, 1'b0);
      exp = '0;
      if (e == 5) exp[1] = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
      if (e >= 9 && e <= 21 && (e % 2) == 1) exp[1] = 1'b1;
`endif
      exp[5] = (e >= 5 && e <= 23);
      if (bus.add_hour) npulse++;
      check("autorep", e, obs(), exp);
    end
`ifdef BTN_AUTO_REPEAT_EN
    check("autorep_count", 0, 6'(npulse), 6'd8);
`else
    check("autorep_count", 0, 6'(npulse), 6'd1);
`endif

    // lockout: add_minute edges 1..6, set_timer edges 3..14, set_timer again 21..26
    for (int e = 1; e <= 33; e++) begin
      raw = '0;
      raw[2] = (e <= 6);
      raw[3] = (e >= 3 && e <= 14) || (e >= 21 && e <= 26);
      tick(raw, 1'b0);
      exp = '0;
      if (e == 5) exp[2] = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
      if (e == 9) exp[2] = 1'b1;
`endif
      if (e == 25) exp[3] = 1'b1;
      exp[5] = (e >= 5 && e <= 18) || (e >= 25 && e <= 30);
      check("lockout", e, obs(), exp);
    end

    // reset while add_hour is held and granted
    for (int e = 1; e <= 12; e++) tick(5'b00010, 1'b0);
    check("pre_reset", 12, obs(), 6'b100000);
    #2;
    reset = 1'b1;
    #1;
    check("reset_async", 0, obs(), 6'b000000);
    for (int i = 1; i <= 2; i++) begin
      tick(5'b00010, 1'b1);
      check("reset_hold", i, obs(), 6'b000000);
    end
    for (int e = 1; e <= 7; e++) begin
      tick(5'b00010, 1'b0);
      exp = '0;
      if (e == 5) exp[1] = 1'b1;
      exp[5] = (e >= 5);
      check("post_reset", e, obs(), exp);
    end

    tick(5'b00000, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
